// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, optional two-entry
// skid buffer (registered ready), pause and flush.
module pipe_stage_reg #(
  parameter int               WIDTH     = 64,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_pause,
  input  logic             i_pre_valid,
  output logic             o_pre_ready,
  input  logic [WIDTH-1:0] i_pre_data,
  output logic             o_post_valid,
  input  logic             i_post_ready,
  output logic [WIDTH-1:0] o_post_data,
  output logic [1:0]       o_occupancy
);

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

  state_t           state, state_nxt;
  logic             main_valid, skid_valid;
  logic             in_fire, out_fire;
  logic             load_in, load_skid, shift_skid;
  logic [WIDTH-1:0] main_data, skid_data;

  assign in_fire     = i_pre_valid & o_pre_ready;
  assign out_fire    = o_post_valid & i_post_ready;
  assign o_post_data = main_data;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  // Next-state and data-load decisions
  always_comb begin
    state_nxt  = state;
    load_in    = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          state_nxt = ST_FULL;
          load_in   = 1'b1;
        end
      end
      ST_FULL: begin
        if (in_fire && out_fire) begin
          load_in = 1'b1;
        end else if (in_fire) begin
          // Without a skid entry ready implies out_fire, so this arm only matters for SKID=1.
          state_nxt = (SKID != 0) ? ST_SKID : ST_FULL;
          load_skid = (SKID != 0);
          load_in   = (SKID == 0);
        end else if (out_fire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_fire) begin
          state_nxt  = ST_FULL;
          shift_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush drops everything, including a payload firing this cycle.
    if (i_flush) begin
      state_nxt  = ST_EMPTY;
      load_in    = 1'b0;
      load_skid  = 1'b0;
      shift_skid = 1'b0;
    end
  end

  // Outputs derived from state
  always_comb begin
    main_valid   = (state != ST_EMPTY);
    skid_valid   = (state == ST_SKID);
    o_post_valid = main_valid & ~i_pause;
    if (SKID != 0) o_pre_ready = ~skid_valid & ~i_pause;
    else           o_pre_ready = ~i_pause & (~main_valid | i_post_ready);
    o_occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_data <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else begin
      if (load_in)         main_data <= i_pre_data;
      else if (shift_skid) main_data <= skid_data;
      if (load_skid)       skid_data <= i_pre_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances side by side, each checked
// every cycle against a queue-based model of a bounded FIFO stage.
module tb_pipe_stage_reg;

  localparam logic [7:0] RV = 8'h3C;

  logic       clk = 1'b0;
  logic       rst, flush, pause, pr;
  logic       pv1, pv0, rdy1, rdy0, vld1, vld0;
  logic [7:0] pd1, pd0, q1, q0;
  logic [1:0] occ1, occ0;

  logic [7:0] m1[$], m0[$], s1[$], s0[$];
  logic [7:0] h1, h0;
  int         errors = 0, checks = 0, cyc = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(8), .SKID(1), .RESET_VAL(RV)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_pause(pause),
    .i_pre_valid(pv1), .o_pre_ready(rdy1), .i_pre_data(pd1),
    .o_post_valid(vld1), .i_post_ready(pr), .o_post_data(q1), .o_occupancy(occ1));

  pipe_stage_reg #(.WIDTH(8), .SKID(0), .RESET_VAL(RV)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_pause(pause),
    .i_pre_valid(pv0), .o_pre_ready(rdy0), .i_pre_data(pd0),
    .o_post_valid(vld0), .i_post_ready(pr), .o_post_data(q0), .o_occupancy(occ0));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One cycle: drive at negedge, check model predictions, advance model at posedge.
  task automatic step(input bit r, input bit fl, input bit pa, input bit prdy, input bit gate);
    bit er1, er0, ev1, ev0, in1, in0, out1, out0;
    rst = r; flush = fl; pause = pa; pr = prdy;
    pv1 = gate && (s1.size() > 0);
    pd1 = (s1.size() > 0) ? s1[0] : 8'h00;
    pv0 = gate && (s0.size() > 0);
    pd0 = (s0.size() > 0) ? s0[0] : 8'h00;
    #1;
    er1 = !pa && (m1.size() < 2);
    er0 = !pa && ((m0.size() == 0) || prdy);
    ev1 = !pa && (m1.size() > 0);
    ev0 = !pa && (m0.size() > 0);
    chk($sformatf("rdy1@%0d", cyc), {7'd0, rdy1}, {7'd0, er1});
    chk($sformatf("vld1@%0d", cyc), {7'd0, vld1}, {7'd0, ev1});
    chk($sformatf("dat1@%0d", cyc), q1, h1);
    chk($sformatf("occ1@%0d", cyc), {6'd0, occ1}, 8'(m1.size()));
    chk($sformatf("rdy0@%0d", cyc), {7'd0, rdy0}, {7'd0, er0});
    chk($sformatf("vld0@%0d", cyc), {7'd0, vld0}, {7'd0, ev0});
    chk($sformatf("dat0@%0d", cyc), q0, h0);
    chk($sformatf("occ0@%0d", cyc), {6'd0, occ0}, 8'(m0.size()));
    in1 = pv1 && er1; out1 = ev1 && prdy;
    in0 = pv0 && er0; out0 = ev0 && prdy;
    @(posedge clk);
    if (r) begin
      m1.delete(); m0.delete(); h1 = RV; h0 = RV;
    end else begin
      if (in1) void'(s1.pop_front());
      if (in0) void'(s0.pop_front());
      if (fl) begin
        m1.delete(); m0.delete();
      end else begin
        if (out1) void'(m1.pop_front());
        if (in1)  m1.push_back(pd1);
        if (out0) void'(m0.pop_front());
        if (in0)  m0.push_back(pd0);
      end
    end
    if (m1.size() > 0) h1 = m1[0];
    if (m0.size() > 0) h0 = m0[0];
    cyc++;
    @(negedge clk);
  endtask

  task automatic push2(input logic [7:0] d);
    s1.push_back(d); s0.push_back(d);
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1; flush = 1'b0; pause = 1'b0; pr = 1'b0;
    pv1 = 1'b0; pv0 = 1'b0; pd1 = 8'h00; pd0 = 8'h00;
    h1 = RV; h0 = RV;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held with a pending 0xAA upstream, then release.
    push2(8'hAA);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("rst_release_occ1", {6'd0, occ1}, 8'd1);
    chk("rst_release_dat1", q1, 8'hAA);
    step(0, 0, 0, 1, 1);

    // Streaming 1..4 with downstream always ready.
    for (int i = 1; i <= 4; i++) push2(8'(i));
    repeat (6) step(0, 0, 0, 1, 1);

    // Backpressure: 5,6,7 with ready dropping once 5 is presented.
    push2(8'd5); push2(8'd6); push2(8'd7);
    step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    chk("bp_occ1", {6'd0, occ1}, 8'd2);
    chk("bp_rdy1", {7'd0, rdy1}, 8'd0);
    chk("bp_occ0", {6'd0, occ0}, 8'd1);
    repeat (6) step(0, 0, 0, 1, 1);

    // Pause while full with both sides willing.
    for (int i = 8; i <= 11; i++) push2(8'(i));
    step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 1, 1, 1);
    repeat (6) step(0, 0, 0, 1, 1);

    // Flush while full with simultaneous in/out fire.
    push2(8'd20); push2(8'd21);
    step(0, 0, 0, 1, 1);
    step(0, 1, 0, 1, 1);
    chk("flush_full_occ1", {6'd0, occ1}, 8'd0);
    step(0, 0, 0, 1, 0);

    // Flush from the skid state, then flush combined with pause.
    push2(8'd30); push2(8'd31); push2(8'd32);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    chk("flush_skid_occ1", {6'd0, occ1}, 8'd0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 1);
    chk("flush_pause_occ1", {6'd0, occ1}, 8'd0);
    chk("flush_pause_occ0", {6'd0, occ0}, 8'd0);
    s1.delete(); s0.delete();
    step(0, 0, 0, 1, 1);

    // Reset mid-transfer.
    push2(8'd40); push2(8'd41);
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    chk("rst_mid_occ1", {6'd0, occ1}, 8'd0);
    step(0, 0, 0, 1, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (s1.size() < 3) begin d = 8'($urandom); s1.push_back(d); end
      if (s0.size() < 3) begin d = 8'($urandom); s0.push_back(d); end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with full valid/ready handshake, an optional two-entry skid buffer, pause and flush. It is the generic replacement for the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage instantiates it once with the stage's payload concatenated into `i_pre_data`. With `SKID=1` it breaks the combinational ready path between stages while still sustaining one transfer per cycle.

## Interface
- `WIDTH`, default 64: payload width in bits, minimum 1.
- `SKID`, default 1: 0 = single register with combinational ready; 1 = two-entry skid buffer with registered ready.
- `RESET_VAL`, default 0: value of the payload registers after reset (`WIDTH` bits).
- `i_clk` input 1: clock. One clock domain; all state updates on the rising edge.
- `i_rst` input 1: reset, synchronous, active-high.
- `i_flush` input 1: discard all held entries.
- `i_pause` input 1: freeze the stage. No accept and no emit.
- `i_pre_valid` input 1: upstream has payload.
- `o_pre_ready` output 1: stage can accept.
- `i_pre_data` input `WIDTH`: upstream payload.
- `o_post_valid` output 1: stage presents payload.
- `i_post_ready` input 1: downstream accepts.
- `o_post_data` output `WIDTH`: payload to downstream.
- `o_occupancy` output 2: number of held entries, 0..2.

## Operation
- Handshakes:
  - `in_fire = i_pre_valid & o_pre_ready`
  - `out_fire = o_post_valid & i_post_ready`
  - A transfer happens only on the fire term of that side.
- Internal state: main entry (`main_valid`, `main_data`) and skid entry (`skid_valid`, `skid_data`). The skid entry exists only when `SKID=1`.
- `o_post_valid = main_valid & !i_pause`. `o_post_data = main_data` at all times; it holds its last value when invalid.
- `o_pre_ready`:
  - `SKID=1`: `!skid_valid & !i_pause`. This is registered state plus `i_pause` only; there is no path from `i_post_ready`.
  - `SKID=0`: `!i_pause & (!main_valid | i_post_ready)`.
- State machine (occupancy) for `SKID=1`:
  - EMPTY, on `in_fire` → FULL, `main_data<=i_pre_data`.
  - FULL, `in_fire & out_fire` → FULL, `main_data<=i_pre_data`.
  - FULL, `in_fire & !out_fire` → SKID, `skid_data<=i_pre_data`.
  - FULL, `!in_fire & out_fire` → EMPTY.
  - SKID, `out_fire` → FULL, `main_data<=skid_data`. No accept is possible in SKID because ready is 0.
  - Otherwise the state holds.
- `SKID=0`: EMPTY/FULL only.
  - `in_fire` → FULL, `main_data<=i_pre_data`. This covers accept in the same cycle as `out_fire`.
  - `out_fire & !in_fire` → EMPTY.
- Ordering: strict FIFO. The skid entry is never emitted ahead of the main entry.
- Pause:
  - Forces both fire terms to 0. State and data are unchanged.
  - Upstream and downstream must not count a transfer while pause is high.
- Flush:
  - At the next edge, `main_valid<=0` and `skid_valid<=0`, so `o_occupancy` becomes 0.
  - Flush overrides any simultaneous `in_fire`/`out_fire`; that payload is dropped, not stored.
  - Flush wins over pause.
  - Data registers keep their contents.
- Reset: overrides flush and pause.
  - `main_valid=0`, `skid_valid=0`.
  - `main_data=RESET_VAL`, `skid_data=RESET_VAL`.
- `o_occupancy = main_valid + skid_valid`.

## Timing
- Latency: payload accepted at edge N is on `o_post_data` with `o_post_valid=1` in the cycle after edge N.
- Throughput: one transfer per cycle in steady state with `i_post_ready=1`, for both `SKID` values.
- Outputs during and after reset (`i_rst` high at an edge):
  - `o_post_valid=0`, `o_post_data=RESET_VAL`, `o_occupancy=0`.
  - `o_pre_ready=1` when `i_pause=0`.
- Backpressure, `SKID=1`:
  - `i_post_ready` drops while FULL and an input arrives: that input lands in skid and `o_pre_ready` goes 0 the next cycle.
  - Ready returns 1 the cycle after the draining `out_fire`.
- Reset asserted mid-transfer: the in-flight handshake is discarded; nothing is emitted after the edge.
- Inputs are sampled only at the rising edge. `o_pre_ready` and `o_post_valid` may change combinationally with `i_pause`; with `SKID=0`, `o_pre_ready` also follows `i_post_ready`.

## Test plan
- Reset with `i_pre_valid=1`, `i_pre_data=0xAA` held → during reset the outputs read `o_post_valid=0`, `o_post_data=RESET_VAL`, `o_occupancy=0`. The first edge after reset releases accepts `0xAA`, and it appears one cycle later.
- Streaming, `SKID=1`, `i_post_ready=1`: send 1,2,3,4 on consecutive cycles → output 1,2,3,4 on consecutive cycles, one cycle delayed, with `o_pre_ready` held at 1.
- Backpressure, `SKID=1`: send 5,6,7 with `i_post_ready=0` from the cycle 5 appears.
  - Expected: occupancy 2, `o_pre_ready=0`, and 7 held upstream.
  - Release `i_post_ready` → output 5,6,7 in order, none lost or duplicated.
- `SKID=0`, same backpressure → occupancy never exceeds 1, `o_pre_ready` tracks `i_post_ready` in the same cycle, and order is preserved.
- `i_pause` for 3 cycles while FULL with `i_post_ready=1` and `i_pre_valid=1` → `o_post_valid=0` and `o_pre_ready=0` throughout; data unchanged; streaming resumes on release.
- `i_flush` in the SKID state, with a simultaneous `in_fire` on the prior cycle's ready → occupancy 0 next cycle and no payload emitted. `i_flush` together with `i_pause` still clears the stage.
